// File: rtl/sr_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_mem_arb_pkg
// Purpose  : Shared types and constants for the IF/D memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sr_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/sr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : sr_arb2
// Purpose  : Two-way combinational grant for IF and D requesters.
//            SR_MEM_ARB_RR_EN selects round-robin; otherwise D beats IF.
// Revision : 1.0 - initial release
// ============================================================================
module sr_arb2
    import sr_mem_arb_pkg::*;
(
    input  logic   if_vld,
    input  logic   d_vld,
`ifdef SR_MEM_ARB_RR_EN
    input  owner_t last_grant,
`endif
    output logic   grant_if,
    output logic   grant_d
);

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_vld && d_vld) begin
`ifdef SR_MEM_ARB_RR_EN
            if (last_grant == OWN_D) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
`else
            grant_d = 1'b1;
`endif
        end else begin
            grant_if = if_vld;
            grant_d  = d_vld;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_mem_arbiter
// Purpose  : Shares one variable-latency memory port between IF and D, one
//            transaction in flight, with a response watchdog.
//            Optional macro SR_MEM_ARB_RR_EN enables round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module sr_mem_arbiter
    import sr_mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_vld,
    output logic              if_rdy,
    output logic [31:0]       if_rdata,
    output logic              if_rsp_vld,

    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [31:0]       d_wdata,
    input  logic              d_vld,
    output logic              d_rdy,
    output logic [31:0]       d_rdata,
    output logic              d_rsp_vld,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              mem_addr_vld,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdata_vld,

    output logic              timeout_err
);

    localparam logic [15:0] c_wdog_last = 16'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [15:0]         r_wdog;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;
    logic                r_timeout_err;

    logic                w_idle;
    logic                w_gnt_if;
    logic                w_gnt_d;

`ifdef SR_MEM_ARB_RR_EN
    owner_t              r_last_grant;
`endif

    assign w_idle = (r_state == IDLE);

    sr_arb2 u_arb (
        .if_vld     (if_vld),
        .d_vld      (d_vld),
`ifdef SR_MEM_ARB_RR_EN
        .last_grant (r_last_grant),
`endif
        .grant_if   (w_gnt_if),
        .grant_d    (w_gnt_d)
    );

    assign if_rdy       = w_idle && w_gnt_if;
    assign d_rdy        = w_idle && w_gnt_d;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_we       = r_we && ((r_state == ISSUE) || (r_state == WAIT));
    assign mem_addr_vld = (r_state == ISSUE);
    assign if_rsp_vld   = (r_state == RESP) && (r_owner == OWN_IF);
    assign d_rsp_vld    = (r_state == RESP) && (r_owner == OWN_D);
    assign if_rdata     = r_if_rdata;
    assign d_rdata      = r_d_rdata;
    assign timeout_err  = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_owner       <= OWN_IF;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_wdog        <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
`ifdef SR_MEM_ARB_RR_EN
            r_last_grant  <= OWN_D;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_d) begin
                        r_owner <= OWN_D;
                        r_addr  <= d_addr;
                        r_we    <= d_we;
                        r_wdata <= d_wdata;
                        r_state <= ISSUE;
`ifdef SR_MEM_ARB_RR_EN
                        r_last_grant <= OWN_D;
`endif
                    end else if (w_gnt_if) begin
                        // Instruction fetch is read-only.
                        r_owner <= OWN_IF;
                        r_addr  <= if_addr;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                        r_state <= ISSUE;
`ifdef SR_MEM_ARB_RR_EN
                        r_last_grant <= OWN_IF;
`endif
                    end
                end
                ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A response arriving on the expiry cycle takes precedence.
                    if (mem_rdata_vld) begin
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= mem_rdata;
                        end else begin
                            r_if_rdata <= mem_rdata;
                        end
                        r_state <= RESP;
                    end else if (r_wdog == c_wdog_last) begin
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= TIMEOUT_DATA;
                        end else begin
                            r_if_rdata <= TIMEOUT_DATA;
                        end
                        r_timeout_err <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_mem_arbiter
// Purpose  : Directed self-checking bench for sr_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_mem_arbiter;

    localparam int C_TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_addr;
    logic        if_vld;
    logic        if_rdy;
    logic [31:0] if_rdata;
    logic        if_rsp_vld;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic        d_vld;
    logic        d_rdy;
    logic [31:0] d_rdata;
    logic        d_rsp_vld;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_addr_vld;
    logic [31:0] mem_rdata;
    logic        mem_rdata_vld;
    logic        timeout_err;

    always #5 clk = ~clk;

    sr_mem_arbiter #(.TIMEOUT_CYCLES(C_TO), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_addr       (if_addr),
        .if_vld        (if_vld),
        .if_rdy        (if_rdy),
        .if_rdata      (if_rdata),
        .if_rsp_vld    (if_rsp_vld),
        .d_addr        (d_addr),
        .d_we          (d_we),
        .d_wdata       (d_wdata),
        .d_vld         (d_vld),
        .d_rdy         (d_rdy),
        .d_rdata       (d_rdata),
        .d_rsp_vld     (d_rsp_vld),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_addr_vld  (mem_addr_vld),
        .mem_rdata     (mem_rdata),
        .mem_rdata_vld (mem_rdata_vld),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic        if_vld;
        logic [31:0] if_addr;
        logic        d_vld;
        logic [31:0] d_addr;
        logic        d_we;
        logic [31:0] d_wdata;
        int          lat;
        logic [31:0] mem_data;
        logic        exp_d;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vecs[6];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    logic        d_known;
    logic        exp_terr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        d_known      = 1'b1;
        exp_terr     = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        @(negedge clk);
        if_vld = v.if_vld; if_addr = v.if_addr;
        d_vld = v.d_vld; d_addr = v.d_addr; d_we = v.d_we; d_wdata = v.d_wdata;
        #1;
        chk("if_rdy", if_rdy, !v.exp_d);
        chk("d_rdy", d_rdy, v.exp_d);
        @(posedge clk);
        #1;
        if_vld = 1'b0; d_vld = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("mem_addr_vld_issue", mem_addr_vld, 1'b1);
        chk("mem_addr", mem_addr, v.exp_addr);
        chk("mem_we", mem_we, v.exp_we);
        if (v.exp_we) chk("mem_wdata", mem_wdata, v.exp_wdata);
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            chk("mem_addr_vld_wait", mem_addr_vld, 1'b0);
            if (k == v.lat) begin
                chk("mem_addr_hold", mem_addr, v.exp_addr);
                mem_rdata_vld = 1'b1;
                mem_rdata     = v.mem_data;
            end
        end
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        mem_rdata     = '0;
        if (v.exp_d) begin
            if (!v.exp_we) begin
                exp_d_rdata = v.mem_data;
                d_known = 1'b1;
            end else begin
                d_known = 1'b0;
            end
        end else begin
            exp_if_rdata = v.mem_data;
        end
        chk("d_rsp_vld", d_rsp_vld, v.exp_d);
        chk("if_rsp_vld", if_rsp_vld, !v.exp_d);
        chk("if_rdata", if_rdata, exp_if_rdata);
        if (d_known) chk("d_rdata", d_rdata, exp_d_rdata);
        chk("timeout_err", timeout_err, exp_terr);
        @(negedge clk);
        chk("rsp_pulse_end", {30'd0, if_rsp_vld, d_rsp_vld}, 32'd0);
    endtask

    initial begin
        int          n;
        int          gcnt;
        logic        pend;
        logic [3:0]  grants;
        logic [3:0]  exp_grants;
        vec_t        v;

        reset_n = 1'b0; if_addr = '0; if_vld = 1'b0; d_addr = '0; d_we = 1'b0;
        d_wdata = '0; d_vld = 1'b0; mem_rdata = '0; mem_rdata_vld = 1'b0;

`ifdef SR_MEM_ARB_RR_EN
        vecs[0] = '{1'b1, 32'h20, 1'b1, 32'h10, 1'b0, 32'h0, 2, 32'h1111_2222, 1'b0, 32'h20, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0, 1, 32'hAAAA_5555, 1'b1, 32'h10, 1'b0, 32'h0};
`else
        vecs[0] = '{1'b1, 32'h20, 1'b1, 32'h10, 1'b0, 32'h0, 2, 32'h1111_2222, 1'b1, 32'h10, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1, 32'hAAAA_5555, 1'b0, 32'h20, 1'b0, 32'h0};
`endif
        vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h5, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b1, 32'h5, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h7, 1'b1, 32'hCAFE_F00D, 2, 32'h0000_0001, 1'b1, 32'h7, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 32'h3FF, 1'b0, 32'h9, 1'b1, 32'h0, C_TO, 32'h600D_600D, 1'b0, 32'h3FF, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0, C_TO - 1, 32'h0BAD_CAFE, 1'b1, 32'h8, 1'b0, 32'h0};

        do_reset();
        @(negedge clk);
        chk("rst_mem_addr_vld", mem_addr_vld, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_rsp", {30'd0, if_rsp_vld, d_rsp_vld}, 32'd0);
        chk("rst_timeout_err", timeout_err, 1'b0);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Silent memory: IF read must abort after the watchdog window.
        @(negedge clk);
        if_vld = 1'b1; if_addr = 32'h44;
        @(posedge clk);
        #1;
        if_vld = 1'b0;
        n = 0;
        for (int k = 1; k <= 30 && n == 0; k++) begin
            @(negedge clk);
            if (if_rsp_vld) n = k;
        end
        chk("timeout_latency", n, C_TO + 2);
        chk("timeout_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("timeout_err_set", timeout_err, 1'b1);
        chk("timeout_d_rsp", d_rsp_vld, 1'b0);
        exp_if_rdata = 32'hDEAD_BEEF;
        exp_terr = 1'b1;
        mem_rdata_vld = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        @(negedge clk);
        chk("late_rsp_ignored", if_rdata, 32'hDEAD_BEEF);
        chk("late_no_pulse", {30'd0, if_rsp_vld, d_rsp_vld}, 32'd0);
        v = vecs[2];
        v.mem_data = 32'h7777_0000;
        do_txn(v);

        // Reset while waiting on memory drops the transaction.
        @(negedge clk);
        d_vld = 1'b1; d_addr = 32'h33;
        @(posedge clk);
        #1;
        d_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rw_mem_addr_vld", mem_addr_vld, 1'b0);
        chk("rw_mem_addr", mem_addr, 32'h0);
        chk("rw_rdata", if_rdata | d_rdata, 32'h0);
        chk("rw_timeout_err", timeout_err, 1'b0);
        chk("rw_rsp", {30'd0, if_rsp_vld, d_rsp_vld}, 32'd0);
        mem_rdata_vld = 1'b1; mem_rdata = 32'h9999_1111;
        @(negedge clk);
        mem_rdata_vld = 1'b0;
        chk("rw_stray_rsp", {30'd0, if_rsp_vld, d_rsp_vld}, 32'd0);
        chk("rw_stray_rdata", d_rdata, 32'h0);
        exp_if_rdata = '0; exp_d_rdata = '0; d_known = 1'b1; exp_terr = 1'b0;
        do_txn(vecs[2]);

        // Both requesters held valid across four back-to-back transactions.
        do_reset();
        @(negedge clk);
        if_vld = 1'b1; if_addr = 32'h100; d_vld = 1'b1; d_addr = 32'h200;
        pend = 1'b0; gcnt = 0; grants = '0;
        for (int k = 0; k < 60 && gcnt < 4; k++) begin
            mem_rdata_vld = pend;
            pend = 1'b0;
            #1;
            if (mem_addr_vld) pend = 1'b1;
            if (d_rdy) begin grants[gcnt] = 1'b1; gcnt++; end
            else if (if_rdy) begin grants[gcnt] = 1'b0; gcnt++; end
            @(negedge clk);
        end
        if_vld = 1'b0; d_vld = 1'b0; mem_rdata_vld = 1'b0;
`ifdef SR_MEM_ARB_RR_EN
        exp_grants = 4'b1010;
`else
        exp_grants = 4'b1111;
`endif
        chk("grant_count", gcnt, 4);
        chk("grant_seq", {28'd0, grants}, {28'd0, exp_grants});

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_mem_arbiter.md
Name: sr_mem_arbiter

Overview:
Shares one latency-variable memory port between the CPU instruction-fetch requester (IF) and a data load/store requester (D). Sits between the multicycle CPU/control FSM and the single memory model.
- Exactly one transaction is outstanding at a time.
- Requests are granted by arbitration, issued on the memory handshake, and the response is routed back to the owner.
- A watchdog covers a memory that never responds.

Parameters:
TIMEOUT_CYCLES, 64, max WAIT cycles before abort; 1..65535.
ADDR_W, 32, word-address width.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
if_addr  in  ADDR_W  IF word address
if_vld  in  1  IF request valid
if_rdy  out  1  IF request accepted this cycle
if_rdata  out  32  IF response data
if_rsp_vld  out  1  IF response pulse
d_addr  in  ADDR_W  D word address
d_we  in  1  D write enable
d_wdata  in  32  D write data
d_vld  in  1  D request valid
d_rdy  out  1  D request accepted this cycle
d_rdata  out  32  D response data (undefined for writes)
d_rsp_vld  out  1  D response/write-ack pulse
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_addr_vld  out  1  memory request pulse
mem_rdata  in  32  memory read data
mem_rdata_vld  in  1  memory response; one per request, writes included
timeout_err  out  1  sticky, set on watchdog abort

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: state=IDLE; all outputs 0, including data buses; watchdog=0; timeout_err=0; last_grant=D.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - if_rdy and d_rdy are combinational: high only in IDLE, and only for the granted requester with vld=1.
  - On a handshake, latch addr/we/wdata and owner, then go to ISSUE.
  - IF requests always have we=0.
- ISSUE:
  - mem_addr_vld=1 for exactly one cycle.
  - mem_addr/mem_we/mem_wdata are driven from the latched registers and held stable until leaving WAIT.
  - Go to WAIT and clear the watchdog.
- WAIT:
  - On mem_rdata_vld, register mem_rdata into the owner's rdata and go to RESP.
  - Otherwise increment the watchdog.
  - When the watchdog reaches TIMEOUT_CYCLES-1 without a response: owner rdata=32'hDEAD_BEEF, set timeout_err, go to RESP.
  - mem_rdata_vld in the same cycle as expiry: the data wins and no error is raised.
- RESP:
  - Owner's rsp_vld=1 for exactly one cycle; rdata holds until the next response to that owner.
  - Go to IDLE; no request is accepted in RESP.
- Latency: handshake at cycle T; mem_addr_vld at T+1; mem_rdata_vld at T+1+L (L≥1); rsp_vld at T+2+L.
- Next accept is no earlier than T+3+L.
- mem_rdata_vld outside WAIT (stray or late after timeout) is ignored and changes no state.
- Default arbitration is fixed priority: D over IF.
- A requester holding vld low in IDLE never blocks the other.
- Reset mid-transaction: return to IDLE immediately and drop the in-flight owner; no rsp_vld is produced for it.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro: SR_MEM_ARB_RR_EN.
- Defined: two-way round-robin. On simultaneous if_vld and d_vld, grant the requester not equal to last_grant. last_grant updates on every handshake and resets to D, so the first conflict goes to IF.
- Undefined: fixed D-over-IF priority; last_grant is unused.

Decomposition:
- Package sr_mem_arb_pkg:
  - typedef enum logic[1:0] state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef enum logic owner_t {OWN_IF, OWN_D}
  - localparam TIMEOUT_DATA = 32'hDEAD_BEEF
- Sub-module sr_arb2: combinational grant from two valids plus last_grant, policy selected by the macro. The FSM, watchdog and response routing stay in the top module.

Test Plan:
- Fixed priority: if_vld=d_vld=1 in IDLE with d_addr=0x10, if_addr=0x20 -> d_rdy=1, if_rdy=0; mem_addr=0x10 at T+1. IF is served next with mem_addr=0x20.
- Read latency: D read at addr 5, memory L=3 returns 0x1234_5678 -> mem_addr_vld at T+1, d_rsp_vld at T+5, d_rdata=0x1234_5678; if_rsp_vld stays 0.
- Write ack: d_we=1, d_wdata=0xCAFE_F00D, addr 7 -> mem_we=1, mem_wdata=0xCAFE_F00D for the request; d_rsp_vld pulses once after the ack.
- Timeout: TIMEOUT_CYCLES=8, memory silent -> if_rsp_vld with if_rdata=0xDEAD_BEEF, timeout_err=1. A late mem_rdata_vld is ignored.
- Round-robin (SR_MEM_ARB_RR_EN): both requesters continuously valid -> grants alternate IF, D, IF, D.
- Reset in WAIT: reset_n=0 for one cycle -> all outputs 0, state IDLE, no rsp_vld. The following mem_rdata_vld is ignored.
